// File: rtl/sorted_merge_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sorted_merge_streamer
// Brief    : Captures two ascending 8-element signed arrays and streams their
//            stable 16-element merge over a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module sorted_merge_streamer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [8*WIDTH-1:0]   a_i,
    input  logic [8*WIDTH-1:0]   b_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 out_src_o,
    output logic [3:0]           out_idx_o
);

    localparam int c_N = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_ia;
    logic [3:0]         r_ib;
    logic [3:0]         r_idx;
    logic [WIDTH-1:0]   r_a [c_N];
    logic [WIDTH-1:0]   r_b [c_N];

    logic [WIDTH-1:0]   w_a_head;
    logic [WIDTH-1:0]   w_b_head;
    logic               w_take_b;
    logic               w_capture;
    logic               w_advance;

    assign w_a_head = r_a[r_ia[2:0]];
    assign w_b_head = r_b[r_ib[2:0]];

    // An exhausted side forces the other; ties keep A first for a stable merge.
    always_comb begin
        w_take_b = 1'b0;
        if (r_ia == 4'd8) begin
            w_take_b = 1'b1;
        end else if (r_ib == 4'd8) begin
            w_take_b = 1'b0;
        end else begin
            w_take_b = !($signed(w_a_head) <= $signed(w_b_head));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_advance = 1'b1;
                    if (r_idx == 4'd15) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ia    <= 4'd0;
            r_ib    <= 4'd0;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_ia  <= 4'd0;
                r_ib  <= 4'd0;
                r_idx <= 4'd0;
            end else if (w_advance) begin
                r_idx <= r_idx + 4'd1;
                if (w_take_b) begin
                    r_ib <= r_ib + 4'd1;
                end else begin
                    r_ia <= r_ia + 4'd1;
                end
            end
        end
    end

    // Array storage carries no reset; it is only observed while streaming.
    generate
        for (genvar g = 0; g < c_N; g++) begin : g_elem
            always_ff @(posedge clk_i) begin
                if (w_capture) begin
                    r_a[g] <= a_i[g*WIDTH +: WIDTH];
                    r_b[g] <= b_i[g*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

    assign out_data_o = (r_state == STREAM) ? (w_take_b ? w_b_head : w_a_head) : '0;
    assign out_src_o  = (r_state == STREAM) && w_take_b;
    assign out_last_o = (r_state == STREAM) && (r_idx == 4'd15);
    assign out_idx_o  = r_idx;

endmodule
`default_nettype wire

// File: doc/sorted_merge_streamer.md
SORTED_MERGE_STREAMER -- requirements
Module: sorted_merge_streamer

Interface
REQ-001 Parameter: WIDTH, 32, element width in bits; elements are two's-complement signed.
REQ-002 Fixed: 8 elements per input array; 16 elements per merged output.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 a_i  input  WIDTH x [8]  array A, ascending sorted by the producer (index 0 smallest).
REQ-006 b_i  input  WIDTH x [8]  array B, ascending sorted by the producer.
REQ-007 in_valid_i  input  1  a_i and b_i hold a valid pair.
REQ-008 in_ready_o  output  1  block can accept a pair this cycle.
REQ-009 out_data_o  output  WIDTH  current merged element, signed.
REQ-010 out_valid_o  output  1  out_data_o is valid.
REQ-011 out_ready_i  input  1  consumer accepts out_data_o this cycle.
REQ-012 out_last_o  output  1  current element is the 16th of the merge.
REQ-013 out_src_o  output  1  source of current element: 0 = A, 1 = B.
REQ-014 out_idx_o  output  4  ordinal of current element, 0..15.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and STREAM.
REQ-016 In IDLE: in_ready_o = 1, out_valid_o = 0.
REQ-017 Input handshake: on a rising edge with in_valid_i = 1 and in_ready_o = 1, both arrays SHALL be captured into internal registers, read pointers ia and ib (0..8) cleared, out_idx cleared, state -> STREAM.
REQ-018 In STREAM: in_ready_o = 0, out_valid_o = 1; no new pair accepted (no overlap between merges).
REQ-019 Latency: out_valid_o SHALL assert the cycle after input acceptance.
REQ-020 Selection: if ia = 8, take B[ib]; else if ib = 8, take A[ia]; else take A[ia] when A[ia] <= B[ib] (signed compare), otherwise B[ib].
REQ-021 Ties SHALL select A, so equal values emit A-before-B (stable merge).
REQ-022 out_data_o, out_src_o, out_last_o and out_idx_o SHALL be derived only from registered state, with no combinational path from a_i, b_i or in_valid_i.
REQ-023 Output transfer occurs on a rising edge with out_valid_o = 1 and out_ready_i = 1; the selected pointer increments by 1 and out_idx increments by 1.
REQ-024 While out_valid_o = 1 and out_ready_i = 0, all outputs SHALL hold stable (no data change, no drop).
REQ-025 out_last_o = 1 exactly when out_idx = 15 in STREAM.
REQ-026 Last transfer (out_idx = 15 accepted): state -> IDLE; in_ready_o = 1 on the next cycle; out_valid_o = 0 on the next cycle.
REQ-027 Every merge SHALL emit exactly 16 elements; each captured element is emitted exactly once, including for unsorted input (emission order then follows REQ-020 literally).
REQ-028 Pointers SHALL never exceed 8; ia + ib = out_idx at all times in STREAM.
REQ-029 Signed extremes (-2^(WIDTH-1), 2^(WIDTH-1)-1) SHALL compare correctly; no overflow arithmetic is used.

Reset
REQ-030 When rst_ni = 0, asynchronously: state = IDLE, ia = ib = 0, out_idx = 0, out_valid_o = 0, out_last_o = 0, out_src_o = 0, out_data_o = 0; in_ready_o = 1 while in IDLE after release.
REQ-031 Reset asserted mid-STREAM SHALL abort the merge; no further elements of that merge are emitted after release.
REQ-032 Captured array registers need no reset.

Verification
REQ-033 A = {1,3,5,7,9,11,13,15}, B = {0,2,4,6,8,10,12,14}, out_ready_i = 1 -> 0..15 emitted on 16 consecutive cycles, first element the cycle after acceptance, out_src_o alternates 1,0,..., out_last_o only with 15.
REQ-034 A = {2,2,2,2,2,2,2,2}, B = {2,2,2,2,2,2,2,2} -> eight elements with out_src_o = 0, then eight with out_src_o = 1.
REQ-035 A = {-2^31,-5,-1,0,0,1,5,2^31-1}, B all 0 -> signed order preserved; out_idx_o 0 = -2^31, out_idx_o 15 = 2^31-1; zeros from A precede zeros from B.
REQ-036 Random out_ready_i with 50% duty -> output stable during stalls, exactly 16 transfers, in_ready_o = 0 throughout STREAM, in_ready_o = 1 the cycle after the last transfer.
REQ-037 rst_ni pulsed low after 5 transfers -> outputs immediately at reset values; next pair after release merges from out_idx_o = 0.
REQ-038 in_valid_i held high across two merges -> second pair is captured on the cycle after the first merge's last transfer; no elements lost or duplicated.
